// File: rtl/up_dn_cmd_pkg.sv
// up_dn_cmd_pkg: shared types and defaults for the up/down counter command front-end
package up_dn_cmd_pkg;
  typedef enum logic [1:0] {IDLE, ARM, PRESSED, DISARM} db_state_t;
  typedef enum logic [2:0] {
    CMD_NONE = 3'b000,
    CMD_UP   = 3'b001,
    CMD_DN   = 3'b010,
    CMD_LD   = 3'b100
  } cmd_t;
  localparam int WIDTH_DEF       = 5;
  localparam int DB_CYCLES_DEF   = 4;
  localparam int HOLD_CYCLES_DEF = 8;
  localparam int REP_CYCLES_DEF  = 4;
endpackage

// File: rtl/up_dn_cmd_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchronizer, debounce FSM and optional auto-repeat producing one-cycle events
module btn_debounce
  import up_dn_cmd_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int REP_CYCLES  = REP_CYCLES_DEF,
  parameter bit REPEAT      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int HN = HOLD_CYCLES > REP_CYCLES ? HOLD_CYCLES : REP_CYCLES;
  localparam int HW = $clog2(HN + 1);
  logic [1:0]    sync;
  logic          s;
  logic          rep;
  logic          press;
  logic          fire;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  db_state_t     state;
  always_comb begin
    s     = sync[1];
    press = state == ARM && s && db_cnt == DW'(DB_CYCLES);
    fire  = REPEAT && state == PRESSED && s &&
            hold_cnt == (rep ? HW'(REP_CYCLES) : HW'(HOLD_CYCLES));
    evt   = press || fire;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], btn};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (s) begin
            state  <= ARM;
            db_cnt <= '0;
          end
        ARM:
          if (!s) state <= IDLE;
          else if (press) state <= PRESSED;
          else db_cnt <= db_cnt + 1'b1;
        PRESSED:
          if (!s) begin
            state  <= DISARM;
            db_cnt <= '0;
          end
        DISARM:
          if (s) state <= PRESSED;
          else if (db_cnt == DW'(DB_CYCLES)) state <= IDLE;
          else db_cnt <= db_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_cnt <= '0;
      rep      <= 1'b0;
    end else if (REPEAT && press) begin
      hold_cnt <= HW'(1);
      rep      <= 1'b0;
    end else if (!REPEAT || state != PRESSED || !s) begin
      hold_cnt <= '0;
      rep      <= 1'b0;
    end else if (fire) begin
      hold_cnt <= HW'(1);
      rep      <= 1'b1;
    end else hold_cnt <= hold_cnt + 1'b1;
endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// up_dn_cmd_ctrl: debounced, arbitrated and saturation-guarded up/down/load strobes for the 5-bit counter
module up_dn_cmd_ctrl
  import up_dn_cmd_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int REP_CYCLES  = REP_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_UP,
  input  logic             BTN_DN,
  input  logic             BTN_LD,
  input  logic [WIDTH-1:0] SW_VAL,
  input  logic             HIGH,
  input  logic             LOW,
  output logic             UP,
  output logic             DOWN,
  output logic             LOAD,
  output logic [WIDTH-1:0] IN_VAL
);
  logic ev_up;
  logic ev_dn;
  logic ev_ld;
  cmd_t cmd;
  btn_debounce #(
    .DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REP_CYCLES(REP_CYCLES), .REPEAT(1'b1)
  ) u_up (.clk(CLK), .rst(RST), .btn(BTN_UP), .evt(ev_up));
  btn_debounce #(
    .DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REP_CYCLES(REP_CYCLES), .REPEAT(1'b1)
  ) u_dn (.clk(CLK), .rst(RST), .btn(BTN_DN), .evt(ev_dn));
  btn_debounce #(
    .DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REP_CYCLES(REP_CYCLES), .REPEAT(1'b0)
  ) u_ld (.clk(CLK), .rst(RST), .btn(BTN_LD), .evt(ev_ld));
  always_comb
    cmd = ev_ld ? CMD_LD :
          ev_dn ? (LOW ? CMD_NONE : CMD_DN) :
          (ev_up && !HIGH) ? CMD_UP : CMD_NONE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      {LOAD, DOWN, UP} <= 3'b000;
      IN_VAL           <= '0;
    end else begin
      {LOAD, DOWN, UP} <= cmd;
      if (cmd == CMD_LD) IN_VAL <= SW_VAL;
    end
endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// tb_up_dn_cmd_ctrl: directed checks of reset, debounce, auto-repeat, priority, saturation and mid-press reset
module tb_up_dn_cmd_ctrl;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int LAT  = 1 + 2 + DB + 1;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_UP = 1'b0;
  logic       BTN_DN = 1'b0;
  logic       BTN_LD = 1'b0;
  logic [4:0] SW_VAL = '0;
  logic       HIGH = 1'b0;
  logic       LOW = 1'b0;
  logic       UP;
  logic       DOWN;
  logic       LOAD;
  logic [4:0] IN_VAL;
  int checks = 0;
  int errors = 0;
  int cu, cd, cl, fu, fd, fl, lv, multi, bounce;
  int dt [16];
  up_dn_cmd_ctrl #(.WIDTH(5), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP)) dut (
    .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
    .SW_VAL(SW_VAL), .HIGH(HIGH), .LOW(LOW), .UP(UP), .DOWN(DOWN), .LOAD(LOAD), .IN_VAL(IN_VAL)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic watch(input int n);
    cu = 0; cd = 0; cl = 0; fu = 0; fd = 0; fl = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (int'(UP) + int'(DOWN) + int'(LOAD) > 1) multi++;
      if (UP) begin
        if (fu == 0) fu = i;
        cu++;
      end
      if (DOWN) begin
        if (fd == 0) fd = i;
        if (cd < 16) dt[cd] = i;
        cd++;
      end
      if (LOAD) begin
        if (fl == 0) fl = i;
        lv = int'(IN_VAL);
        cl++;
      end
    end
  endtask
  task automatic idle_all(input string tag);
    BTN_UP = 0; BTN_DN = 0; BTN_LD = 0;
    watch(20);
    chk(tag, cu + cd + cl, 0);
  endtask
  initial begin
    multi = 0; bounce = 0; lv = 0;
    RST = 1; BTN_UP = 1; BTN_DN = 1; BTN_LD = 1; SW_VAL = 5'd9;
    repeat (3) tick();
    chk("rst_up", UP, 0);
    chk("rst_dn", DOWN, 0);
    chk("rst_ld", LOAD, 0);
    chk("rst_inval", IN_VAL, 0);
    RST = 0;
    watch(LAT);
    chk("rst_ld_cnt", cl, 1);
    chk("rst_ld_lat", fl, LAT);
    chk("rst_ld_val", lv, 9);
    chk("rst_updn", cu + cd, 0);
    idle_all("rst_quiet");
    for (int i = 0; i < 10; i++) begin
      BTN_UP = (i % 2 == 0);
      watch(2);
      bounce += cu + cd + cl;
    end
    chk("bounce", bounce, 0);
    BTN_UP = 1;
    watch(LAT);
    chk("db_up_cnt", cu, 1);
    chk("db_up_lat", fu, LAT);
    idle_all("db_quiet");
    BTN_DN = 1;
    watch(40);
    chk("rep_cnt", cd, 8);
    chk("rep_first", dt[0], LAT);
    chk("rep_hold", dt[1], LAT + HOLD);
    chk("rep_period", dt[2], LAT + HOLD + REP);
    chk("rep_last", dt[7], LAT + HOLD + 6 * REP);
    chk("rep_other", cu + cl, 0);
    idle_all("rep_quiet");
    SW_VAL = 5'd16;
    BTN_LD = 1; BTN_DN = 1; BTN_UP = 1;
    watch(LAT);
    chk("pri_ld_cnt", cl, 1);
    chk("pri_ld_lat", fl, LAT);
    chk("pri_ld_val", lv, 16);
    chk("pri_updn", cu + cd, 0);
    idle_all("pri_quiet");
    chk("inval_hold", IN_VAL, 16);
    HIGH = 1;
    BTN_UP = 1;
    watch(20);
    chk("sat_high", cu, 0);
    idle_all("sat_high_quiet");
    HIGH = 0; LOW = 1;
    BTN_DN = 1;
    watch(20);
    chk("sat_low", cd, 0);
    idle_all("sat_low_quiet");
    SW_VAL = 5'd31; HIGH = 1; LOW = 1;
    BTN_LD = 1;
    watch(30);
    chk("sat_ld_cnt", cl, 1);
    chk("sat_ld_lat", fl, LAT);
    chk("sat_ld_val", lv, 31);
    idle_all("sat_ld_quiet");
    HIGH = 0; LOW = 0;
    BTN_UP = 1;
    watch(LAT + HOLD);
    chk("mid_cnt", cu, 2);
    chk("mid_live", UP, 1);
    RST = 1;
    #1;
    chk("mid_async", UP, 0);
    tick();
    tick();
    chk("mid_held", UP, 0);
    chk("mid_inval", IN_VAL, 0);
    RST = 0;
    watch(LAT);
    chk("mid_again_cnt", cu, 1);
    chk("mid_again_lat", fu, LAT);
    idle_all("mid_quiet");
    chk("exclusive", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
